dmem_responder: RTL and testbench

- Data-memory responder: the memory-side end of the CPU's STUR/LDUR load/store path.
- Accepts one load or store request at a time through a valid/ready handshake and waits a programmable number of access cycles.
- Returns a response (read data or write acknowledge) through a valid/ready handshake.
- Holds a 16 x 16-bit register-file memory; replaces the free-running we/oe/addr bus access with a flow-controlled interface.

---
 rtl/dmem_responder.sv | 170 +++++++++++++++++
 tb/tb_dmem_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - flow-controlled data-memory responder for the load/store path
//
// Purpose: accepts one load or store request at a time over a valid/ready
// handshake, spends LATENCY access cycles, commits the access into a
// 2**AW x WIDTH register-file memory and returns a response over a
// valid/ready handshake.
//
// Parameters: WIDTH (data width), AW (address width), LATENCY (0..15 BUSY cycles).
// Optional feature: define DMEM_STATS_EN to add saturating statistics outputs.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid / req_ready         request handshake
//   req_we, req_oe                store / load request (both set = error)
//   req_addr, req_wdata           word address, store data
//   resp_valid / resp_ready       response handshake
//   resp_rdata                    load data, zero for store and error responses
//   resp_err                      request had both req_we and req_oe set
//   stat_loads/stores/errs        (DMEM_STATS_EN only) committed response counts
module dmem_responder #(
  parameter int WIDTH   = 16,
  parameter int AW      = 4,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic             req_oe,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]      stat_loads,
  output logic [15:0]      stat_stores,
  output logic [15:0]      stat_errs
`endif
);

  localparam int DEPTH = 1 << AW;
  // BUSY counts down from LATENCY-1 to 0, giving exactly LATENCY BUSY cycles.
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic             lat_we;
  logic             lat_oe;
  logic [AW-1:0]    lat_addr;
  logic [WIDTH-1:0] lat_wdata;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             accept;
  logic             commit;
  logic             c_we;
  logic             c_oe;
  logic [AW-1:0]    c_addr;
  logic [WIDTH-1:0] c_wdata;

  // With LATENCY = 0 the commit happens on the accept edge, before the
  // latches hold the request, so the commit operands come straight from the
  // request inputs while in IDLE and from the latches otherwise.
  always_comb begin
    accept = (state == IDLE) && req_valid && (req_we || req_oe);
    if (state == IDLE) begin
      c_we    = req_we;
      c_oe    = req_oe;
      c_addr  = req_addr;
      c_wdata = req_wdata;
    end else begin
      c_we    = lat_we;
      c_oe    = lat_oe;
      c_addr  = lat_addr;
      c_wdata = lat_wdata;
    end
    if (LATENCY == 0) begin
      commit = accept;
    end else begin
      commit = (state == BUSY) && (cnt == 4'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_oe     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
`ifdef DMEM_STATS_EN
      stat_loads  <= 16'd0;
      stat_stores <= 16'd0;
      stat_errs   <= 16'd0;
`endif
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_oe    <= req_oe;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        req_ready <= 1'b0;
      end

      if (commit) begin
        // Commit point: the memory side effect and the response data are
        // produced on the edge that enters RESP.
        state      <= RESP;
        resp_valid <= 1'b1;
        if (c_we && c_oe) begin
          resp_err   <= 1'b1;
          resp_rdata <= '0;
`ifdef DMEM_STATS_EN
          if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
`endif
        end else if (c_we) begin
          mem[c_addr] <= c_wdata;
          resp_rdata  <= '0;
`ifdef DMEM_STATS_EN
          if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
`endif
        end else begin
          resp_rdata <= mem[c_addr];
`ifdef DMEM_STATS_EN
          if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
`endif
        end
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              state <= BUSY;
              cnt   <= LAT_M1;
            end
          end
          BUSY: begin
            cnt <= cnt - 4'd1;
          end
          RESP: begin
            // req_ready returns only after the handshake edge, so no request
            // can be accepted in the handshake cycle itself.
            if (resp_ready) begin
              state      <= IDLE;
              resp_valid <= 1'b0;
              resp_err   <= 1'b0;
              req_ready  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder at LATENCY 0, 1 and 15
module tb_dmem_responder;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_we = 1'b0;
  logic req_oe = 1'b0;
  logic [3:0] req_addr = 4'd0;
  logic [15:0] req_wdata = 16'd0;
  logic resp_ready = 1'b0;

  logic [NI-1:0]       rdy;
  logic [NI-1:0]       rv;
  logic [NI-1:0]       err;
  logic [NI-1:0][15:0] rdata;
`ifdef DMEM_STATS_EN
  logic [NI-1:0][15:0] sl;
  logic [NI-1:0][15:0] ss;
  logic [NI-1:0][15:0] se;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int ecnt  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ecnt++;

  dmem_responder #(.WIDTH(16), .AW(4), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_we(req_we), .req_oe(req_oe), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv[0]), .resp_ready(resp_ready), .resp_rdata(rdata[0]), .resp_err(err[0])
`ifdef DMEM_STATS_EN
    , .stat_loads(sl[0]), .stat_stores(ss[0]), .stat_errs(se[0])
`endif
  );

  dmem_responder #(.WIDTH(16), .AW(4), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_we(req_we), .req_oe(req_oe), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv[1]), .resp_ready(resp_ready), .resp_rdata(rdata[1]), .resp_err(err[1])
`ifdef DMEM_STATS_EN
    , .stat_loads(sl[1]), .stat_stores(ss[1]), .stat_errs(se[1])
`endif
  );

  dmem_responder #(.WIDTH(16), .AW(4), .LATENCY(15)) u_l15 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]),
    .req_we(req_we), .req_oe(req_oe), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv[2]), .resp_ready(resp_ready), .resp_rdata(rdata[2]), .resp_err(err[2])
`ifdef DMEM_STATS_EN
    , .stat_loads(sl[2]), .stat_stores(ss[2]), .stat_errs(se[2])
`endif
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 15);
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [LATENCY=%0d] got %h expected %h at t=%0t", nm, lat_of(k), act, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding request per responder, a
  // countdown of cycles until its response shows, and the memory contents.
  logic        m_busy [NI];
  int          m_rem  [NI];
  logic [15:0] m_rdata[NI];
  logic        m_err  [NI];
  logic [15:0] m_mem  [NI][16];
  int          m_ld   [NI];
  int          m_st   [NI];
  int          m_er   [NI];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0;
        m_rem[k] = 0;
        m_rdata[k] = 16'd0;
        m_err[k] = 1'b0;
        m_ld[k] = 0;
        m_st[k] = 0;
        m_er[k] = 0;
        for (int a = 0; a < 16; a++) m_mem[k][a] = 16'd0;
      end else if (m_busy[k] && m_rem[k] == 0) begin
        if (resp_ready) m_busy[k] = 1'b0;
      end else if (m_busy[k]) begin
        m_rem[k] = m_rem[k] - 1;
      end else if (req_valid && (req_we || req_oe)) begin
        m_busy[k] = 1'b1;
        m_rem[k] = lat_of(k);
        if (req_we && req_oe) begin
          m_err[k] = 1'b1;
          m_rdata[k] = 16'd0;
          m_er[k]++;
        end else if (req_we) begin
          m_err[k] = 1'b0;
          m_mem[k][req_addr] = req_wdata;
          m_rdata[k] = 16'd0;
          m_st[k]++;
        end else begin
          m_err[k] = 1'b0;
          m_rdata[k] = m_mem[k][req_addr];
          m_ld[k]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NI; k++) begin
        logic ev;
        ev = m_busy[k] && (m_rem[k] == 0);
        chk("req_ready", k, rdy[k], !m_busy[k]);
        chk("resp_valid", k, rv[k], ev);
        chk("resp_err", k, err[k], ev && m_err[k]);
        if (ev) chk("resp_rdata", k, rdata[k], m_rdata[k]);
      end
    end
  end

  int          cap_lat  [NI];
  logic [15:0] cap_rdata[NI];
  logic        cap_err  [NI];

  // Issue one request to all responders, hold resp_ready low until every
  // responder shows a response (plus 'hold' extra cycles carrying an
  // ignored store request), then complete the handshake.
  task automatic txn(input logic we, input logic oe, input logic [3:0] a,
                     input logic [15:0] d, input int hold);
    logic [NI-1:0] seen;
    int e0;
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_oe = oe; req_addr = a; req_wdata = d;
    resp_ready = 1'b0;
    e0 = ecnt + 1;
    seen = '0;
    guard = 0;
    for (int k = 0; k < NI; k++) cap_lat[k] = -1;
    do begin
      @(negedge clk);
      guard++;
      for (int k = 0; k < NI; k++) begin
        if (rv[k] && !seen[k]) begin
          seen[k] = 1'b1;
          cap_lat[k] = ecnt - e0 + 1;
        end
      end
    end while (seen != '1 && guard < 40);
    chk("resp_timeout", 0, 32'(seen), 32'd7);
    if (hold > 0) begin
      req_valid = 1'b1; req_we = 1'b1; req_oe = 1'b0; req_addr = 4'd3; req_wdata = 16'hDEAD;
      repeat (hold) @(negedge clk);
    end
    req_valid = 1'b0;
    for (int k = 0; k < NI; k++) begin
      cap_rdata[k] = rdata[k];
      cap_err[k] = err[k];
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk({tag, "_req_ready"}, k, rdy[k], 1'b1);
      chk({tag, "_resp_valid"}, k, rv[k], 1'b0);
      chk({tag, "_resp_rdata"}, k, rdata[k], 16'd0);
      chk({tag, "_resp_err"}, k, err[k], 1'b0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    txn(1'b1, 1'b0, 4'd3, 16'h0055, 0);
    for (int k = 0; k < NI; k++) begin
      chk("store_latency", k, cap_lat[k], lat_of(k) + 1);
      chk("store_rdata", k, cap_rdata[k], 16'h0000);
      chk("store_err", k, cap_err[k], 1'b0);
    end

    txn(1'b0, 1'b1, 4'd3, 16'h0000, 5);
    for (int k = 0; k < NI; k++) chk("held_load_rdata", k, cap_rdata[k], 16'h0055);

    txn(1'b1, 1'b1, 4'd3, 16'hFFFF, 0);
    for (int k = 0; k < NI; k++) begin
      chk("error_err", k, cap_err[k], 1'b1);
      chk("error_rdata", k, cap_rdata[k], 16'h0000);
    end

    txn(1'b0, 1'b1, 4'd3, 16'h0000, 0);
    for (int k = 0; k < NI; k++) chk("after_error_load", k, cap_rdata[k], 16'h0055);

    txn(1'b1, 1'b0, 4'd15, 16'hA5C3, 0);
    txn(1'b0, 1'b1, 4'd15, 16'h0000, 0);
    for (int k = 0; k < NI; k++) begin
      chk("addr15_latency", k, cap_lat[k], lat_of(k) + 1);
      chk("addr15_rdata", k, cap_rdata[k], 16'hA5C3);
    end

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_oe = 1'b0; req_addr = 4'd7; req_wdata = 16'h1234;
    @(negedge clk);
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midop_reset");
    @(negedge clk);
    rst = 1'b0;
    txn(1'b0, 1'b1, 4'd7, 16'h0000, 0);
    for (int k = 0; k < NI; k++) chk("after_reset_load7", k, cap_rdata[k], 16'h0000);

    repeat (3000) begin
      @(negedge clk);
      req_valid  = ($urandom_range(0, 1) == 1);
      req_we     = ($urandom_range(0, 1) == 1);
      req_oe     = ($urandom_range(0, 1) == 1);
      req_addr   = 4'($urandom_range(0, 15));
      req_wdata  = 16'($urandom);
      resp_ready = ($urandom_range(0, 9) < 6);
    end
    @(negedge clk);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    repeat (40) @(negedge clk);
    resp_ready = 1'b0;
    for (int k = 0; k < NI; k++) chk("drained_ready", k, rdy[k], 1'b1);

`ifdef DMEM_STATS_EN
    for (int k = 0; k < NI; k++) begin
      chk("stat_loads", k, sl[k], 16'(m_ld[k]));
      chk("stat_stores", k, ss[k], 16'(m_st[k]));
      chk("stat_errs", k, se[k], 16'(m_er[k]));
    end
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("stat_loads_rst", k, sl[k], 16'd0);
      chk("stat_stores_rst", k, ss[k], 16'd0);
      chk("stat_errs_rst", k, se[k], 16'd0);
    end
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
